// File: rtl/mole_hit_judge_if.sv
// Bus between the mole generator, the player buttons, the mole digit of the
// display and the scoreboard logic on one side and the round judge on the other.
interface mole_hit_judge_if;
   logic        tick;
   logic        start;
   logic [3:0]  level;
   logic [6:0]  mole_seg;
   logic [3:0]  mole_anode;
   logic [2:0]  mole_type;
   logic [3:0]  btn;

   logic [6:0]  disp_seg;
   logic [3:0]  disp_anode;
   logic [13:0] score;
   logic [1:0]  lives;
   logic        hit_pulse;
   logic        miss_pulse;
   logic        game_over;

   modport master (
      output tick, start, level, mole_seg, mole_anode, mole_type, btn,
      input  disp_seg, disp_anode, score, lives, hit_pulse, miss_pulse, game_over
   );

   modport slave (
      input  tick, start, level, mole_seg, mole_anode, mole_type, btn,
      output disp_seg, disp_anode, score, lives, hit_pulse, miss_pulse, game_over
   );
endinterface

// File: rtl/mole_hit_judge.sv
// Round controller: latches one mole per round, shows it for a level-dependent
// window, judges button presses against it and keeps score and lives.
module mole_hit_judge #(
   parameter int unsigned BASE_WIN_MS = 1200,
   parameter int unsigned STEP_MS     = 100,
   parameter int unsigned MIN_WIN_MS  = 400,
   parameter int unsigned GAP_MS      = 300,
   parameter int unsigned RESULT_MS   = 200,
   parameter int unsigned START_LIVES = 3
) (
   input logic             clk,
   input logic             restart_n,
   mole_hit_judge_if.slave bus
);

   localparam logic [2:0]  ST_IDLE   = 3'd0;
   localparam logic [2:0]  ST_GAP    = 3'd1;
   localparam logic [2:0]  ST_SHOW   = 3'd2;
   localparam logic [2:0]  ST_RESULT = 3'd3;
   localparam logic [2:0]  ST_OVER   = 3'd4;

   localparam logic [11:0] BASE_W   = 12'(BASE_WIN_MS);
   localparam logic [11:0] STEP_W   = 12'(STEP_MS);
   localparam logic [11:0] MIN_W    = 12'(MIN_WIN_MS);
   localparam logic [11:0] GAP_W    = 12'(GAP_MS);
   localparam logic [11:0] RESULT_W = 12'(RESULT_MS);

   localparam logic [1:0]  LIVES_INIT = 2'(START_LIVES);
   localparam logic [6:0]  SEG_BLANK  = 7'h7F;
   localparam logic [6:0]  SEG_DASH   = 7'b0111111;
   localparam logic [3:0]  AN_OFF     = 4'hF;
   localparam logic [13:0] SCORE_MAX  = 14'd9999;

   logic [2:0]  state;
   logic [11:0] timer;
   logic [3:0]  btn_q;
   logic [3:0]  press_q;
   logic [3:0]  anode_cap;
   logic [2:0]  type_cap;

   logic [6:0]  disp_seg_r;
   logic [3:0]  disp_anode_r;
   logic [13:0] score_r;
   logic [1:0]  lives_r;
   logic        hit_r;
   logic        miss_r;
   logic        over_r;

   logic [11:0] level_dec;
   logic [11:0] win_len;
   logic        timer_done;
   logic        mole_void;
   logic        press_any;
   logic        press_hit;
   logic [13:0] points;
   logic [14:0] score_sum;
   logic [13:0] score_next;
   logic [1:0]  lives_dec;

   assign bus.disp_seg   = disp_seg_r;
   assign bus.disp_anode = disp_anode_r;
   assign bus.score      = score_r;
   assign bus.lives      = lives_r;
   assign bus.hit_pulse  = hit_r;
   assign bus.miss_pulse = miss_r;
   assign bus.game_over  = over_r;

   // The comparison is made first so the subtraction is only used when it
   // cannot wrap below the floor.
   assign level_dec = 12'(bus.level) * STEP_W;

   always_comb begin
      if (level_dec + MIN_W >= BASE_W) begin
         win_len = MIN_W;
      end else begin
         win_len = BASE_W - level_dec;
      end
   end

   assign timer_done = bus.tick && (timer == 12'd1);
   assign mole_void  = (bus.mole_type == 3'd6) || ($countones(~bus.mole_anode) != 1);
   assign press_any  = |press_q;
   assign press_hit  = ($countones(press_q) == 1) && (press_q == ~anode_cap)
                       && (type_cap != 3'd0);

   always_comb begin
      case (type_cap)
         3'd1:    points = 14'd1;
         3'd2:    points = 14'd3;
         3'd3:    points = 14'd10;
         default: points = 14'd0;
      endcase
   end

   assign score_sum  = {1'b0, score_r} + {1'b0, points};
   assign score_next = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[13:0];
   assign lives_dec  = (lives_r == 2'd0) ? 2'd0 : lives_r - 2'd1;

   // The edge register runs in every state so a button already held when the
   // mole appears never counts as a fresh press.
   always_ff @(posedge clk or negedge restart_n) begin
      if (!restart_n) begin
         state        <= ST_IDLE;
         timer        <= 12'd0;
         btn_q        <= 4'd0;
         press_q      <= 4'd0;
         anode_cap    <= AN_OFF;
         type_cap     <= 3'd0;
         disp_seg_r   <= SEG_BLANK;
         disp_anode_r <= AN_OFF;
         score_r      <= 14'd0;
         lives_r      <= LIVES_INIT;
         hit_r        <= 1'b0;
         miss_r       <= 1'b0;
         over_r       <= 1'b0;
      end else begin
         btn_q   <= bus.btn;
         press_q <= bus.btn & ~btn_q;
         hit_r   <= 1'b0;
         miss_r  <= 1'b0;

         case (state)
            ST_IDLE, ST_OVER: begin
               if (bus.start) begin
                  state        <= ST_GAP;
                  timer        <= GAP_W;
                  score_r      <= 14'd0;
                  lives_r      <= LIVES_INIT;
                  over_r       <= 1'b0;
                  disp_seg_r   <= SEG_BLANK;
                  disp_anode_r <= AN_OFF;
               end
            end

            ST_GAP: begin
               if (timer_done) begin
                  if (mole_void) begin
                     timer <= GAP_W;
                  end else begin
                     state        <= ST_SHOW;
                     timer        <= win_len;
                     anode_cap    <= bus.mole_anode;
                     type_cap     <= bus.mole_type;
                     disp_seg_r   <= bus.mole_seg;
                     disp_anode_r <= bus.mole_anode;
                  end
               end else if (bus.tick) begin
                  timer <= timer - 12'd1;
               end
            end

            // A press seen on the same edge as the last window tick takes priority.
            ST_SHOW: begin
               if (press_any) begin
                  if (press_hit) begin
                     score_r <= score_next;
                     hit_r   <= 1'b1;
                  end else begin
                     lives_r <= lives_dec;
                     miss_r  <= 1'b1;
                  end
                  state      <= ST_RESULT;
                  timer      <= RESULT_W;
                  disp_seg_r <= SEG_DASH;
               end else if (timer_done) begin
                  if (type_cap != 3'd0) begin
                     lives_r <= lives_dec;
                     miss_r  <= 1'b1;
                  end
                  state      <= ST_RESULT;
                  timer      <= RESULT_W;
                  disp_seg_r <= SEG_DASH;
               end else if (bus.tick) begin
                  timer <= timer - 12'd1;
               end
            end

            ST_RESULT: begin
               if (timer_done) begin
                  disp_seg_r   <= SEG_BLANK;
                  disp_anode_r <= AN_OFF;
                  if (lives_r == 2'd0) begin
                     state  <= ST_OVER;
                     over_r <= 1'b1;
                  end else begin
                     state <= ST_GAP;
                     timer <= GAP_W;
                  end
               end else if (bus.tick) begin
                  timer <= timer - 12'd1;
               end
            end

            default: begin
               state        <= ST_IDLE;
               disp_seg_r   <= SEG_BLANK;
               disp_anode_r <= AN_OFF;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mole_hit_judge.sv
// Scoreboard bench for mole_hit_judge: each round pushes its expected outcome,
// the display monitor pops it when the result dash appears.
module tb_mole_hit_judge;

   localparam int BASE  = 40;
   localparam int STEP  = 2;
   localparam int MIN   = 12;
   localparam int GAP   = 3;
   localparam int RES   = 4;
   localparam int LIVES = 3;

   localparam logic [6:0] DASH  = 7'b0111111;
   localparam logic [6:0] BLANK = 7'h7F;
   localparam logic [6:0] MOLE  = 7'h12;

   typedef struct {
      int hit;
      int miss;
      int score;
      int lives;
      int show_len;
   } exp_t;

   logic clk;
   logic restart_n;

   mole_hit_judge_if bus ();

   mole_hit_judge #(
      .BASE_WIN_MS (BASE),
      .STEP_MS     (STEP),
      .MIN_WIN_MS  (MIN),
      .GAP_MS      (GAP),
      .RESULT_MS   (RES),
      .START_LIVES (LIVES)
   ) dut (
      .clk       (clk),
      .restart_n (restart_n),
      .bus       (bus)
   );

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb_q[$];
   exp_t e;
   int   exp_score = 0;
   int   exp_lives = LIVES;
   int   results   = 0;
   int   shows     = 0;
   int   show_cnt  = 0;
   int   res_cnt   = 0;
   int   res_len_exp = 0;
   bit   prev_dash = 0;
   bit   is_dash;
   bit   is_mole;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // tick is high on every other clock so per-clk judging and per-tick timing differ
   initial begin
      bus.tick = 1'b0;
      forever begin
         @(posedge clk);
         #1 bus.tick = ~bus.tick;
      end
   end

   task automatic checkOutput(input string tag, input int obs, input int expv);
      n_checks++;
      if (obs == expv) n_pass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
   endtask

   function automatic int win_ticks(input int lvl);
      int w;
      w = BASE - lvl * STEP;
      if (w < MIN) w = MIN;
      return w;
   endfunction

   function automatic int type_points(input int t);
      case (t)
         1:       return 1;
         2:       return 3;
         3:       return 10;
         default: return 0;
      endcase
   endfunction

   // Display monitor: the first dash cycle of each round is where the pulses,
   // score and lives of the round are compared.
   always @(negedge clk) begin
      if (!restart_n) begin
         show_cnt  = 0;
         res_cnt   = 0;
         prev_dash = 0;
      end else begin
         is_dash = (bus.disp_anode != 4'hF) && (bus.disp_seg == DASH);
         is_mole = (bus.disp_anode != 4'hF) && !is_dash;
         if (is_mole) begin
            if (show_cnt == 0) shows++;
            show_cnt++;
         end
         if (is_dash && !prev_dash) begin
            res_len_exp = bus.tick ? 2 * RES - 1 : 2 * RES;
            res_cnt = 1;
            if (sb_q.size() == 0) begin
               checkOutput("sb_underflow", 1, 0);
            end else begin
               e = sb_q.pop_front();
               checkOutput("hit_pulse",  int'(bus.hit_pulse),  e.hit);
               checkOutput("miss_pulse", int'(bus.miss_pulse), e.miss);
               checkOutput("score",      int'(bus.score),      e.score);
               checkOutput("lives",      int'(bus.lives),      e.lives);
               checkOutput("show_len",   show_cnt,             e.show_len);
            end
            show_cnt = 0;
            results++;
         end else if (is_dash) begin
            res_cnt++;
            if (res_cnt == 2) checkOutput("pulse_width", int'(bus.hit_pulse | bus.miss_pulse), 0);
         end else if (prev_dash) begin
            checkOutput("result_len", res_cnt, res_len_exp);
         end
         prev_dash = is_dash;
      end
   end

   task automatic wait_show(output bit ok);
      ok = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (bus.disp_anode != 4'hF && bus.disp_seg != DASH) begin
            ok = 1;
            break;
         end
      end
      if (!ok) checkOutput("show_timeout", 0, 1);
   endtask

   task automatic wait_result();
      int  r0;
      bit  ok;
      r0 = results;
      ok = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (results != r0) begin
            ok = 1;
            break;
         end
      end
      if (!ok) checkOutput("result_timeout", 0, 1);
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // One round: k is the number of clocks after the mole appears before the
   // press is driven (-1 for no press); hold drives the buttons before the mole.
   task automatic applyStimulus(input int mtype, input logic [3:0] anode, input int lvl,
                                input int lvl_show, input logic [3:0] mask, input int k,
                                input bit hold);
      exp_t x;
      bit   ok;
      int   s0, r0;
      bus.mole_type  = 3'(mtype);
      bus.mole_anode = anode;
      bus.mole_seg   = MOLE;
      bus.level      = 4'(lvl);
      if (hold) bus.btn = mask;
      if (mtype == 6 || $countones(~anode) != 1) begin
         s0 = shows;
         r0 = results;
         repeat (40) @(negedge clk);
         checkOutput("void_shows",   shows,            s0);
         checkOutput("void_results", results,          r0);
         checkOutput("void_score",   int'(bus.score),  exp_score);
         checkOutput("void_lives",   int'(bus.lives),  exp_lives);
         return;
      end
      x.hit  = 0;
      x.miss = 0;
      if (k >= 0) begin
         if (mask == ~anode && mtype != 0) x.hit = 1;
         else x.miss = 1;
         x.show_len = k + 2;
      end else begin
         if (mtype != 0) x.miss = 1;
         x.show_len = 2 * win_ticks(lvl);
      end
      if (x.hit != 0) begin
         exp_score = exp_score + type_points(mtype);
         if (exp_score > 9999) exp_score = 9999;
      end
      if (x.miss != 0 && exp_lives > 0) exp_lives--;
      x.score = exp_score;
      x.lives = exp_lives;
      sb_q.push_back(x);
      wait_show(ok);
      bus.level = 4'(lvl_show);
      if (ok && k >= 0) begin
         repeat (k) @(posedge clk);
         #1 bus.btn = mask;
      end
      wait_result();
      bus.btn = 4'b0000;
   endtask

   task automatic wait_over();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.game_over) break;
      end
      checkOutput("game_over",  int'(bus.game_over),  1);
      checkOutput("over_seg",   int'(bus.disp_seg),   int'(BLANK));
      checkOutput("over_anode", int'(bus.disp_anode), 15);
      checkOutput("over_lives", int'(bus.lives),      0);
   endtask

   task automatic check_restart();
      pulse_start();
      @(negedge clk);
      exp_score = 0;
      exp_lives = LIVES;
      checkOutput("restart_score", int'(bus.score),     0);
      checkOutput("restart_lives", int'(bus.lives),     LIVES);
      checkOutput("restart_over",  int'(bus.game_over), 0);
   endtask

   task automatic check_reset_values(input string pfx);
      checkOutput({pfx, "_seg"},   int'(bus.disp_seg),   int'(BLANK));
      checkOutput({pfx, "_anode"}, int'(bus.disp_anode), 15);
      checkOutput({pfx, "_score"}, int'(bus.score),      0);
      checkOutput({pfx, "_lives"}, int'(bus.lives),      LIVES);
      checkOutput({pfx, "_hit"},   int'(bus.hit_pulse),  0);
      checkOutput({pfx, "_miss"},  int'(bus.miss_pulse), 0);
      checkOutput({pfx, "_over"},  int'(bus.game_over),  0);
   endtask

   initial begin
      bit ok;
      int r0;
      restart_n      = 1'b0;
      bus.start      = 1'b0;
      bus.level      = 4'd0;
      bus.mole_seg   = MOLE;
      bus.mole_anode = 4'b1101;
      bus.mole_type  = 3'd1;
      bus.btn        = 4'b0000;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      restart_n = 1'b1;
      pulse_start();

      // Scoring, plague handling and bad presses until the lives run out.
      applyStimulus(1, 4'b1101, 0,  0,  4'b0010, 10, 0);
      applyStimulus(3, 4'b1011, 15, 15, 4'b0100, 5,  0);
      applyStimulus(2, 4'b0111, 3,  3,  4'b1000, 1,  0);
      applyStimulus(0, 4'b1101, 5,  5,  4'b0000, -1, 0);
      applyStimulus(0, 4'b1110, 0,  0,  4'b0001, 3,  0);
      applyStimulus(2, 4'b1110, 0,  0,  4'b0010, 7,  0);
      applyStimulus(2, 4'b0111, 0,  0,  4'b1001, 4,  0);
      wait_over();

      r0 = results;
      bus.btn = 4'b0001;
      repeat (10) @(negedge clk);
      bus.btn = 4'b0000;
      checkOutput("over_ignore_results", results,          r0);
      checkOutput("over_ignore_score",   int'(bus.score),  exp_score);
      check_restart();

      // Void moles, held button, press on the last tick, level change mid-window.
      applyStimulus(6, 4'b1101, 0,  0,  4'b0000, -1, 0);
      applyStimulus(1, 4'b1001, 0,  0,  4'b0000, -1, 0);
      applyStimulus(1, 4'b1101, 0,  0,  4'b0010, -1, 1);
      applyStimulus(1, 4'b1011, 0,  0,  4'b0100, 2 * win_ticks(0) - 2, 0);
      applyStimulus(1, 4'b1110, 15, 0,  4'b0000, -1, 0);
      applyStimulus(1, 4'b1110, 2,  2,  4'b0000, -1, 0);
      wait_over();
      check_restart();

      // Drive the score into saturation with master chief hits.
      for (int i = 0; i < 1001; i++) begin
         applyStimulus(3, 4'b1110, 0, 0, 4'b0001, 0, 0);
      end
      checkOutput("score_saturated", int'(bus.score), 9999);

      // Abandon a round mid-window: every output returns to reset at once.
      bus.mole_type  = 3'd1;
      bus.mole_anode = 4'b1101;
      wait_show(ok);
      restart_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      repeat (3) @(negedge clk);
      checkOutput("sb_empty", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
